// File: rtl/tile_sched_pkg.sv
// Shared types and helpers for the GEMM tile scheduler.
// Optional feature macro: TILE_SCHED_PERF_EN (used by tile_scheduler).
package tile_sched_pkg;

  localparam int DIM_W_DEF = 32;
  // Arithmetic width for index/extent math; wide enough that idx+T never overflows.
  localparam int CALC_W    = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMP_GO,
    S_COMP_WAIT,
    S_ADVANCE,
    S_DONE
  } state_t;

  // Candidate next tile origin along one dimension.
  function automatic logic [CALC_W-1:0] next_idx(input logic [CALC_W-1:0] idx,
                                                 input logic [CALC_W-1:0] t);
    return idx + t;
  endfunction

  // Extent of a tile starting at idx: min(t, d - idx). Caller guarantees idx <= d.
  function automatic logic [CALC_W-1:0] tile_len(input logic [CALC_W-1:0] d,
                                                 input logic [CALC_W-1:0] t,
                                                 input logic [CALC_W-1:0] idx);
    logic [CALC_W-1:0] rem;
    rem = d - idx;
    return (t < rem) ? t : rem;
  endfunction

endpackage

// File: rtl/tile_dim_iter.sv
// One dimension of the tile loop nest: holds the tile origin and extent,
// and flags when the next step would leave the dimension.
module tile_dim_iter
  import tile_sched_pkg::*;
#(
  parameter int DIM_W = DIM_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_step,
  input  logic [DIM_W-1:0] i_cfg_d,
  input  logic [DIM_W-1:0] i_cfg_t,
  output logic [DIM_W-1:0] o_idx,
  output logic [DIM_W-1:0] o_len,
  output logic             o_wrap
);

  logic [DIM_W-1:0]  r_idx;
  logic [DIM_W-1:0]  r_len;
  logic [CALC_W-1:0] w_next;
  logic [DIM_W-1:0]  w_len_first;
  logic [DIM_W-1:0]  w_len_next;

  // Wrap is judged on the widened sum so idx+T overflowing DIM_W still wraps.
  assign w_next      = next_idx(CALC_W'(r_idx), CALC_W'(i_cfg_t));
  assign o_wrap      = (w_next >= CALC_W'(i_cfg_d));
  assign w_len_first = DIM_W'(tile_len(CALC_W'(i_cfg_d), CALC_W'(i_cfg_t), '0));
  assign w_len_next  = DIM_W'(tile_len(CALC_W'(i_cfg_d), CALC_W'(i_cfg_t), w_next));

  // Origin/extent register: clear to the first tile, step or wrap on advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_len <= '0;
    end else if (i_clear) begin
      r_idx <= '0;
      r_len <= w_len_first;
    end else if (i_step) begin
      if (o_wrap) begin
        r_idx <= '0;
        r_len <= w_len_first;
      end else begin
        r_idx <= DIM_W'(w_next);
        r_len <= w_len_next;
      end
    end
  end

  assign o_idx = r_idx;
  assign o_len = r_len;

endmodule

// File: rtl/tile_scheduler.sv
// GEMM tile scheduler: walks tile origins m->n->k (k innermost), issuing a
// load handshake then a compute handshake per tile, ping-ponging A/B banks.
// Optional feature macro: TILE_SCHED_PERF_EN adds perf_tiles/perf_stall counters.
module tile_scheduler
  import tile_sched_pkg::*;
#(
  parameter int DIM_W = DIM_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_pulse,
  input  logic             abort_pulse,
  input  logic             irq_en,
  input  logic [DIM_W-1:0] cfg_M,
  input  logic [DIM_W-1:0] cfg_N,
  input  logic [DIM_W-1:0] cfg_K,
  input  logic [DIM_W-1:0] cfg_Tm,
  input  logic [DIM_W-1:0] cfg_Tn,
  input  logic [DIM_W-1:0] cfg_Tk,
  output logic             load_req,
  input  logic             load_ack,
  output logic             comp_start,
  input  logic             comp_done,
  output logic [DIM_W-1:0] m_idx,
  output logic [DIM_W-1:0] n_idx,
  output logic [DIM_W-1:0] k_idx,
  output logic [DIM_W-1:0] m_len,
  output logic [DIM_W-1:0] n_len,
  output logic [DIM_W-1:0] k_len,
  output logic             bank_sel_wr,
  output logic             bank_sel_rd,
  output logic             busy,
  output logic             done_tile_pulse,
  output logic             job_done_pulse,
  output logic             irq
`ifdef TILE_SCHED_PERF_EN
  ,
  output logic [DIM_W-1:0] perf_tiles,
  output logic [DIM_W-1:0] perf_stall
`endif
);

  state_t           r_state;
  state_t           w_next;
  logic [DIM_W-1:0] r_M, r_N, r_K, r_Tm, r_Tn, r_Tk;
  logic [DIM_W-1:0] w_d_m, w_d_n, w_d_k, w_t_m, w_t_n, w_t_k;
  logic             w_accept, w_abort, w_adv, w_zero_dim;
  logic             w_wrap_m, w_wrap_n, w_wrap_k;
  logic             r_bank_wr, r_bank_rd, r_job_done, r_irq;

  assign w_accept   = (r_state == S_IDLE) && start_pulse;
  assign w_abort    = (r_state != S_IDLE) && abort_pulse;
  assign w_adv      = (r_state == S_ADVANCE) && !w_abort;
  assign w_zero_dim = (cfg_M == '0) || (cfg_N == '0) || (cfg_K == '0);

  // Iterators see live config in the accept cycle, latched config afterwards.
  assign w_d_m = w_accept ? cfg_M  : r_M;
  assign w_d_n = w_accept ? cfg_N  : r_N;
  assign w_d_k = w_accept ? cfg_K  : r_K;
  assign w_t_m = w_accept ? cfg_Tm : r_Tm;
  assign w_t_n = w_accept ? cfg_Tn : r_Tn;
  assign w_t_k = w_accept ? cfg_Tk : r_Tk;

  tile_dim_iter #(.DIM_W(DIM_W)) u_iter_m (
    .clk(clk), .rst_n(rst_n), .i_clear(w_accept),
    .i_step(w_adv && w_wrap_k && w_wrap_n),
    .i_cfg_d(w_d_m), .i_cfg_t(w_t_m),
    .o_idx(m_idx), .o_len(m_len), .o_wrap(w_wrap_m)
  );

  tile_dim_iter #(.DIM_W(DIM_W)) u_iter_n (
    .clk(clk), .rst_n(rst_n), .i_clear(w_accept),
    .i_step(w_adv && w_wrap_k),
    .i_cfg_d(w_d_n), .i_cfg_t(w_t_n),
    .o_idx(n_idx), .o_len(n_len), .o_wrap(w_wrap_n)
  );

  tile_dim_iter #(.DIM_W(DIM_W)) u_iter_k (
    .clk(clk), .rst_n(rst_n), .i_clear(w_accept),
    .i_step(w_adv),
    .i_cfg_d(w_d_k), .i_cfg_t(w_t_k),
    .o_idx(k_idx), .o_len(k_len), .o_wrap(w_wrap_k)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and state-decoded handshake/status outputs; abort overrides all.
  always_comb begin
    w_next          = r_state;
    load_req        = 1'b0;
    comp_start      = 1'b0;
    done_tile_pulse = 1'b0;
    busy            = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:      if (start_pulse) w_next = w_zero_dim ? S_DONE : S_LOAD;
      S_LOAD: begin
        load_req = 1'b1;
        if (load_ack) w_next = S_COMP_GO;
      end
      S_COMP_GO: begin
        comp_start = 1'b1;
        w_next     = S_COMP_WAIT;
      end
      S_COMP_WAIT: if (comp_done) w_next = S_ADVANCE;
      S_ADVANCE: begin
        done_tile_pulse = w_wrap_k && !abort_pulse;
        w_next = (w_wrap_k && w_wrap_n && w_wrap_m) ? S_DONE : S_LOAD;
      end
      S_DONE:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  // Job configuration captured when a start is accepted.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_M  <= cfg_M;
      r_N  <= cfg_N;
      r_K  <= cfg_K;
      r_Tm <= cfg_Tm;
      r_Tn <= cfg_Tn;
      r_Tk <= cfg_Tk;
    end
  end

  // Bank ping-pong: the bank just filled becomes the read bank on each load ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank_wr <= 1'b0;
      r_bank_rd <= 1'b0;
    end else if ((r_state == S_LOAD) && load_ack && !w_abort) begin
      r_bank_rd <= r_bank_wr;
      r_bank_wr <= ~r_bank_wr;
    end
  end

  // Job completion pulse follows DONE by one cycle; irq follows the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_job_done <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_job_done <= (r_state == S_DONE) && !abort_pulse;
      r_irq      <= r_job_done && irq_en;
    end
  end

  assign bank_sel_wr    = r_bank_wr;
  assign bank_sel_rd    = r_bank_rd;
  assign job_done_pulse = r_job_done;
  assign irq            = r_irq;

`ifdef TILE_SCHED_PERF_EN
  logic [DIM_W-1:0] r_perf_tiles;
  logic [DIM_W-1:0] r_perf_stall;

  // Saturating job counters: completed computes and cycles spent waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_tiles <= '0;
      r_perf_stall <= '0;
    end else if (w_accept) begin
      r_perf_tiles <= '0;
      r_perf_stall <= '0;
    end else begin
      if ((r_state == S_COMP_WAIT) && comp_done && !w_abort && !(&r_perf_tiles))
        r_perf_tiles <= r_perf_tiles + 1'b1;
      if (((r_state == S_LOAD) || (r_state == S_COMP_WAIT)) && !(&r_perf_stall))
        r_perf_stall <= r_perf_stall + 1'b1;
    end
  end

  assign perf_tiles = r_perf_tiles;
  assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_tile_scheduler.sv
// Directed self-checking bench for tile_scheduler (default build).
module tb_tile_scheduler;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_pulse = 1'b0;
  logic         abort_pulse = 1'b0;
  logic         irq_en = 1'b0;
  logic         load_ack = 1'b0;
  logic         comp_done = 1'b0;
  logic [W-1:0] cfg_M = '0, cfg_N = '0, cfg_K = '0;
  logic [W-1:0] cfg_Tm = 1, cfg_Tn = 1, cfg_Tk = 1;
  logic         load_req, comp_start, bank_sel_wr, bank_sel_rd, busy;
  logic         done_tile_pulse, job_done_pulse, irq;
  logic [W-1:0] m_idx, n_idx, k_idx, m_len, n_len, k_len;

  int n_checks = 0;
  int n_errors = 0;

  // Job recorder state, filled by run_job
  int comp_cnt, dt_cnt, jd_cnt, irq_cnt, toggles, ack_cnt;
  bit finished;
  logic ab_load_req, ab_comp_start, ab_busy;
  logic [W-1:0] rec_m [16];
  logic [W-1:0] rec_n [16];
  logic [W-1:0] rec_k [16];
  logic [W-1:0] rec_ml[16];
  logic [W-1:0] rec_nl[16];
  logic [W-1:0] rec_kl[16];

  tile_scheduler #(.DIM_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start_pulse(start_pulse), .abort_pulse(abort_pulse),
    .irq_en(irq_en), .cfg_M(cfg_M), .cfg_N(cfg_N), .cfg_K(cfg_K),
    .cfg_Tm(cfg_Tm), .cfg_Tn(cfg_Tn), .cfg_Tk(cfg_Tk),
    .load_req(load_req), .load_ack(load_ack), .comp_start(comp_start), .comp_done(comp_done),
    .m_idx(m_idx), .n_idx(n_idx), .k_idx(k_idx), .m_len(m_len), .n_len(n_len), .k_len(k_len),
    .bank_sel_wr(bank_sel_wr), .bank_sel_rd(bank_sel_rd), .busy(busy),
    .done_tile_pulse(done_tile_pulse), .job_done_pulse(job_done_pulse), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic set_cfg(input logic [W-1:0] m, n, k, tm, tn, tk);
    cfg_M = m; cfg_N = n; cfg_K = k; cfg_Tm = tm; cfg_Tn = tn; cfg_Tk = tk;
  endtask

  // Starts a job and plays the DMA/core responder until job end or abort.
  // comp_done follows comp_start by one cycle; load_ack comes ack_dly cycles
  // after load_req first appears. abort_tile>0 aborts in that tile's COMP_WAIT.
  // inject drives start_pulse and comp_done in the first LOAD cycle of tile 2.
  task automatic run_job(input int ack_dly, input int abort_tile, input bit inject);
    int req_age, done_timer, post_cnt, ab_cyc;
    bit abort_next, aborted;
    logic prev_wr;
    comp_cnt = 0; dt_cnt = 0; jd_cnt = 0; irq_cnt = 0; toggles = 0; ack_cnt = 0;
    finished = 0; req_age = 0; done_timer = 0; post_cnt = 0; ab_cyc = 0;
    abort_next = 0; aborted = 0;
    ab_load_req = 1'bx; ab_comp_start = 1'bx; ab_busy = 1'bx;
    @(negedge clk);
    prev_wr = bank_sel_wr;
    start_pulse = 1'b1;
    @(negedge clk);
    for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
      start_pulse = 1'b0; load_ack = 1'b0; comp_done = 1'b0; abort_pulse = 1'b0;
      if (aborted) begin
        ab_cyc++;
        if (ab_cyc == 1) begin
          ab_load_req = load_req; ab_comp_start = comp_start; ab_busy = busy;
        end
        if (ab_cyc == 3) finished = 1;
      end
      if (job_done_pulse) jd_cnt++;
      if (irq) irq_cnt++;
      if (done_tile_pulse) dt_cnt++;
      if (bank_sel_wr !== prev_wr) toggles++;
      prev_wr = bank_sel_wr;
      if (comp_start) begin
        if (comp_cnt < 16) begin
          rec_m[comp_cnt] = m_idx; rec_n[comp_cnt] = n_idx; rec_k[comp_cnt] = k_idx;
          rec_ml[comp_cnt] = m_len; rec_nl[comp_cnt] = n_len; rec_kl[comp_cnt] = k_len;
        end
        comp_cnt++;
        if (comp_cnt == abort_tile) abort_next = 1;
        else done_timer = 1;
      end else if (abort_next) begin
        abort_pulse = 1'b1; abort_next = 0; aborted = 1;
      end else if (done_timer > 0) begin
        done_timer--;
        if (done_timer == 0) comp_done = 1'b1;
      end
      if (load_req) begin
        req_age++;
        if (inject && ack_cnt == 1 && req_age == 1) begin
          start_pulse = 1'b1; comp_done = 1'b1;
        end
        if (req_age == ack_dly + 1) begin
          load_ack = 1'b1; ack_cnt++;
        end
      end else begin
        req_age = 0;
      end
      if (jd_cnt > 0) begin
        post_cnt++;
        if (post_cnt == 4) finished = 1;
      end
      @(negedge clk);
    end
    start_pulse = 1'b0; load_ack = 1'b0; comp_done = 1'b0; abort_pulse = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_checks++; if (load_req !== 1'b0) begin n_errors++; $display("FAIL reset_load_req: got %0b expected 0", load_req); end
    n_checks++; if (comp_start !== 1'b0) begin n_errors++; $display("FAIL reset_comp_start: got %0b expected 0", comp_start); end
    n_checks++; if ({bank_sel_wr, bank_sel_rd} !== 2'b00) begin n_errors++; $display("FAIL reset_banks: got %0b%0b expected 00", bank_sel_wr, bank_sel_rd); end
    n_checks++; if ({job_done_pulse, done_tile_pulse, irq} !== 3'b000) begin n_errors++; $display("FAIL reset_pulses: got %0b%0b%0b expected 000", job_done_pulse, done_tile_pulse, irq); end
    n_checks++; if ({m_idx, n_idx, k_idx, m_len, n_len, k_len} !== '0) begin n_errors++; $display("FAIL reset_idx_len: got m%0h n%0h k%0h ml%0h nl%0h kl%0h expected all 0", m_idx, n_idx, k_idx, m_len, n_len, k_len); end
  endtask

  task automatic test_full_job();
    set_cfg(4, 4, 4, 2, 2, 2);
    irq_en = 1'b1;
    run_job(1, 0, 0);
    n_checks++; if (finished !== 1'b1) begin n_errors++; $display("FAIL full_timeout: got finished=%0b expected 1", finished); end
    n_checks++; if (comp_cnt !== 8) begin n_errors++; $display("FAIL full_tiles: got %0d expected 8", comp_cnt); end
    n_checks++; if (dt_cnt !== 4) begin n_errors++; $display("FAIL full_done_tiles: got %0d expected 4", dt_cnt); end
    n_checks++; if (jd_cnt !== 1) begin n_errors++; $display("FAIL full_job_done: got %0d expected 1", jd_cnt); end
    n_checks++; if (irq_cnt !== 1) begin n_errors++; $display("FAIL full_irq: got %0d expected 1", irq_cnt); end
    n_checks++; if (toggles !== 8) begin n_errors++; $display("FAIL full_bank_toggles: got %0d expected 8", toggles); end
    n_checks++; if ({bank_sel_wr, bank_sel_rd} !== 2'b01) begin n_errors++; $display("FAIL full_bank_final: got wr%0b rd%0b expected wr0 rd1", bank_sel_wr, bank_sel_rd); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL full_busy_after: got %0b expected 0", busy); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (rec_k[i] !== W'((i % 2) * 2) || rec_n[i] !== W'(((i / 2) % 2) * 2) || rec_m[i] !== W'((i / 4) * 2))
      begin n_errors++; $display("FAIL full_origin_%0d: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", i, rec_m[i], rec_n[i], rec_k[i], (i / 4) * 2, ((i / 2) % 2) * 2, (i % 2) * 2); end
    end
    irq_en = 1'b0;
  endtask

  task automatic test_ragged();
    set_cfg(5, 3, 2, 2, 2, 2);
    run_job(0, 0, 0);
    n_checks++; if (finished !== 1'b1) begin n_errors++; $display("FAIL ragged_timeout: got finished=%0b expected 1", finished); end
    n_checks++; if (comp_cnt !== 6) begin n_errors++; $display("FAIL ragged_tiles: got %0d expected 6", comp_cnt); end
    n_checks++; if (irq_cnt !== 0) begin n_errors++; $display("FAIL ragged_irq_disabled: got %0d expected 0", irq_cnt); end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (rec_m[i] !== W'((i / 2) * 2) || rec_ml[i] !== W'((i / 2 == 2) ? 1 : 2) ||
          rec_n[i] !== W'((i % 2) * 2) || rec_nl[i] !== W'((i % 2 == 1) ? 1 : 2) ||
          rec_k[i] !== '0 || rec_kl[i] !== W'(2))
      begin n_errors++; $display("FAIL ragged_tile_%0d: got m%0d/%0d n%0d/%0d k%0d/%0d", i, rec_m[i], rec_ml[i], rec_n[i], rec_nl[i], rec_k[i], rec_kl[i]); end
    end
  endtask

  task automatic test_zero_dim(input logic en);
    set_cfg(0, 4, 4, 2, 2, 2);
    irq_en = en;
    @(negedge clk); start_pulse = 1'b1;
    @(negedge clk); start_pulse = 1'b0;
    n_checks++; if ({busy, load_req, job_done_pulse} !== 3'b100) begin n_errors++; $display("FAIL zero_t1: got busy%0b req%0b jd%0b expected busy1 req0 jd0", busy, load_req, job_done_pulse); end
    @(negedge clk);
    n_checks++; if ({busy, load_req, job_done_pulse, irq} !== 4'b0010) begin n_errors++; $display("FAIL zero_t2: got busy%0b req%0b jd%0b irq%0b expected busy0 req0 jd1 irq0", busy, load_req, job_done_pulse, irq); end
    @(negedge clk);
    n_checks++; if ({job_done_pulse, irq} !== {1'b0, en}) begin n_errors++; $display("FAIL zero_irq_en%0b: got jd%0b irq%0b expected jd0 irq%0b", en, job_done_pulse, irq, en); end
    irq_en = 1'b0;
  endtask

  task automatic test_abort();
    set_cfg(4, 4, 4, 2, 2, 2);
    run_job(1, 3, 0);
    n_checks++; if (finished !== 1'b1) begin n_errors++; $display("FAIL abort_timeout: got finished=%0b expected 1", finished); end
    n_checks++; if ({ab_load_req, ab_comp_start, ab_busy} !== 3'b000) begin n_errors++; $display("FAIL abort_after: got req%0b cs%0b busy%0b expected 000", ab_load_req, ab_comp_start, ab_busy); end
    n_checks++; if (jd_cnt !== 0 || comp_cnt !== 3) begin n_errors++; $display("FAIL abort_counts: got jd%0d tiles%0d expected jd0 tiles3", jd_cnt, comp_cnt); end
    n_checks++; if ({m_idx, n_idx, k_idx} !== {W'(0), W'(2), W'(0)}) begin n_errors++; $display("FAIL abort_hold_idx: got (%0d,%0d,%0d) expected (0,2,0)", m_idx, n_idx, k_idx); end
    run_job(1, 0, 0);
    n_checks++; if (finished !== 1'b1 || comp_cnt !== 8 || dt_cnt !== 4 || jd_cnt !== 1) begin n_errors++; $display("FAIL abort_rerun: got fin%0b tiles%0d dt%0d jd%0d expected 1/8/4/1", finished, comp_cnt, dt_cnt, jd_cnt); end
  endtask

  task automatic test_ignored();
    set_cfg(4, 4, 4, 2, 2, 2);
    run_job(1, 0, 1);
    n_checks++; if (finished !== 1'b1) begin n_errors++; $display("FAIL ignore_timeout: got finished=%0b expected 1", finished); end
    n_checks++; if (comp_cnt !== 8 || dt_cnt !== 4 || jd_cnt !== 1) begin n_errors++; $display("FAIL ignore_counts: got tiles%0d dt%0d jd%0d expected 8/4/1", comp_cnt, dt_cnt, jd_cnt); end
    n_checks++; if (rec_k[1] !== W'(2) || rec_n[2] !== W'(2)) begin n_errors++; $display("FAIL ignore_sequence: got k1=%0d n2=%0d expected 2,2", rec_k[1], rec_n[2]); end
  endtask

  task automatic test_overflow();
    set_cfg(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    run_job(0, 0, 0);
    n_checks++; if (finished !== 1'b1 || comp_cnt !== 8) begin n_errors++; $display("FAIL ovf_tiles: got fin%0b tiles%0d expected 1/8", finished, comp_cnt); end
    n_checks++; if (rec_ml[0] !== 32'h8000_0000 || rec_kl[0] !== 32'h8000_0000) begin n_errors++; $display("FAIL ovf_first_len: got m%0h k%0h expected 80000000", rec_ml[0], rec_kl[0]); end
    n_checks++; if ({rec_ml[7], rec_nl[7], rec_kl[7]} !== {3{32'h7FFF_FFFF}}) begin n_errors++; $display("FAIL ovf_last_len: got %0h %0h %0h expected 7fffffff", rec_ml[7], rec_nl[7], rec_kl[7]); end
    n_checks++; if ({rec_m[7], rec_n[7], rec_k[7]} !== {3{32'h8000_0000}}) begin n_errors++; $display("FAIL ovf_last_idx: got %0h %0h %0h expected 80000000", rec_m[7], rec_n[7], rec_k[7]); end
  endtask

  task automatic test_reset_midjob();
    set_cfg(4, 4, 4, 2, 2, 2);
    @(negedge clk); start_pulse = 1'b1;
    @(negedge clk); start_pulse = 1'b0;
    @(negedge clk);
    n_checks++; if (load_req !== 1'b1) begin n_errors++; $display("FAIL midrst_in_load: got %0b expected 1", load_req); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({busy, load_req, k_len} !== {2'b00, W'(0)}) begin n_errors++; $display("FAIL midrst_cleared: got busy%0b req%0b klen%0h expected 0 0 0", busy, load_req, k_len); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_full_job();
    test_ragged();
    test_zero_dim(1'b0);
    test_zero_dim(1'b1);
    test_abort();
    test_ignored();
    test_overflow();
    test_reset_midjob();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
